// File: rtl/stv_aes_pkg.sv
// Shared AES types and helpers for the crypto subsystem.
// Byte k of a 128-bit block lives in bits [127-8k -: 8]; row = k%4, column = k/4.
package stv_aes_pkg;

  localparam int AES_NB    = 4;
  localparam int AES_BYTES = 4 * AES_NB;

  // Indexed by byte number k, so s[4*c+r] is row r, column c.
  typedef logic [AES_BYTES-1:0][7:0] aes_state_t;

  // Legal round counts: AES-128/192/256.
  function automatic bit aes_rounds_ok(int r);
    return (r == 10) || (r == 12) || (r == 14);
  endfunction

  function automatic aes_state_t aes_unpack(logic [127:0] d);
    aes_state_t s;
    for (int k = 0; k < AES_BYTES; k++) s[k] = d[127-8*k -: 8];
    return s;
  endfunction

  function automatic logic [127:0] aes_pack(aes_state_t s);
    logic [127:0] d;
    for (int k = 0; k < AES_BYTES; k++) d[127-8*k -: 8] = s[k];
    return d;
  endfunction

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_mul2(logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/stv_aes_decipher_if.sv
// Ciphertext-in / plaintext-out streams plus the round-key lookup port.
interface stv_aes_decipher_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [3:0]   rk_idx;
  logic [127:0] rk_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;

  modport slave (
    input  in_valid, in_data, rk_data, out_ready,
    output in_ready, rk_idx, out_valid, out_data, busy
  );

  modport master (
    output in_valid, in_data, rk_data, out_ready,
    input  in_ready, rk_idx, out_valid, out_data, busy
  );
endinterface

// File: rtl/stv_aes_inv_mixcolumns.sv
// InvMixColumns on one 32-bit column; row 0 is col_in[31:24].
module stv_aes_inv_mixcolumns
  import stv_aes_pkg::*;
(
  input  logic [31:0] col_in,
  output logic [31:0] col_out
);

  logic [3:0][7:0] m9, mb, md, me;

  // Build the {09,0b,0d,0e} multiples of every byte from repeated doubling.
  always_comb begin
    logic [7:0] a, x2, x4, x8;
    m9 = '0;
    mb = '0;
    md = '0;
    me = '0;
    for (int i = 0; i < 4; i++) begin
      a     = col_in[31-8*i -: 8];
      x2    = gf_mul2(a);
      x4    = gf_mul2(x2);
      x8    = gf_mul2(x4);
      m9[i] = x8 ^ a;
      mb[i] = x8 ^ x2 ^ a;
      md[i] = x8 ^ x4 ^ a;
      me[i] = x8 ^ x4 ^ x2;
    end
  end

  // Row i uses the circulant {0e,0b,0d,09} starting at row i.
  always_comb begin
    col_out = '0;
    for (int i = 0; i < 4; i++)
      col_out[31-8*i -: 8] = me[i] ^ mb[(i+1)%4] ^ md[(i+2)%4] ^ m9[(i+3)%4];
  end

endmodule

// File: rtl/stv_aes_subbytes.sv
// Byte-parallel AES S-box, forward or inverse, computed from the GF(2^8)
// inverse and the affine map rather than a stored table.
module stv_aes_subbytes
  import stv_aes_pkg::*;
#(
  parameter int BYTES = 16
) (
  input  logic                  inverse,
  input  logic [BYTES-1:0][7:0] din,
  output logic [BYTES-1:0][7:0] dout
);

  function automatic logic [7:0] gf_mul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = gf_mul2(t);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse, and maps 0 to 0 as the S-box needs.
  function automatic logic [7:0] gf_inv(logic [7:0] a);
    logic [7:0] r;
    logic [7:0] p;
    logic [7:0] e;
    r = 8'h01;
    p = a;
    e = 8'hfe;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = gf_mul(r, p);
      p = gf_mul(p, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] affine(logic [7:0] a);
    return a ^ {a[6:0], a[7]} ^ {a[5:0], a[7:6]} ^ {a[4:0], a[7:5]} ^
           {a[3:0], a[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_affine(logic [7:0] s);
    return {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
  endfunction

  for (genvar i = 0; i < BYTES; i++) begin : g_byte
    assign dout[i] = inverse ? gf_inv(inv_affine(din[i])) : affine(gf_inv(din[i]));
  end

endmodule

// File: rtl/stv_aes_decipher.sv
// Iterative AES inverse cipher: one full inverse round per clock.
// Round keys are fetched by index from external key-schedule storage.
module stv_aes_decipher
  import stv_aes_pkg::*;
#(
  parameter int ROUNDS = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  stv_aes_decipher_if.slave   bus
);

  if (!aes_rounds_ok(ROUNDS)) begin : g_bad_rounds
    $error("stv_aes_decipher: ROUNDS must be 10, 12 or 14");
  end

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ROUND = 2'd1;
  localparam logic [1:0] S_FINAL = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [3:0] RK_LAST = 4'(ROUNDS);

  logic [1:0]      fsm;
  logic [3:0]      cnt;
  logic [127:0]    st;

  aes_state_t      cur, isr, sb, ark, imc;
  logic [3:0][31:0] ark_cols, imc_cols;

  // InvShiftRows: row r rotates right by r, so new column c takes old column c-r.
  always_comb begin
    cur = aes_unpack(st);
    isr = '0;
    for (int c = 0; c < AES_NB; c++)
      for (int r = 0; r < 4; r++)
        isr[4*c+r] = cur[4*((c-r+4)%4)+r];
  end

  stv_aes_subbytes #(.BYTES(AES_BYTES)) u_isb (
    .inverse (1'b1),
    .din     (isr),
    .dout    (sb)
  );

  assign ark = sb ^ aes_unpack(bus.rk_data);

  for (genvar c = 0; c < AES_NB; c++) begin : g_col
    assign ark_cols[c] = {ark[4*c], ark[4*c+1], ark[4*c+2], ark[4*c+3]};

    stv_aes_inv_mixcolumns u_imc (
      .col_in  (ark_cols[c]),
      .col_out (imc_cols[c])
    );

    assign {imc[4*c], imc[4*c+1], imc[4*c+2], imc[4*c+3]} = imc_cols[c];
  end

  // Control FSM, round counter and the state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm <= S_IDLE;
      cnt <= '0;
      st  <= '0;
    end else begin
      case (fsm)
        S_IDLE: begin
          if (bus.in_valid) begin
            st  <= bus.in_data ^ bus.rk_data;
            cnt <= RK_LAST - 4'd1;
            fsm <= S_ROUND;
          end
        end
        S_ROUND: begin
          st  <= aes_pack(imc);
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) fsm <= S_FINAL;
        end
        S_FINAL: begin
          // Last round skips InvMixColumns.
          st  <= aes_pack(ark);
          fsm <= S_DONE;
        end
        default: begin
          // S_DONE: st holds until the plaintext is taken.
          if (bus.out_ready) fsm <= S_IDLE;
        end
      endcase
    end
  end

  // Key index: last key while waiting, counter during rounds, key 0 afterwards.
  always_comb begin
    case (fsm)
      S_IDLE:  bus.rk_idx = RK_LAST;
      S_ROUND: bus.rk_idx = cnt;
      default: bus.rk_idx = 4'd0;
    endcase
  end

  assign bus.in_ready  = (fsm == S_IDLE);
  assign bus.out_valid = (fsm == S_DONE);
  assign bus.out_data  = st;
  assign bus.busy      = (fsm == S_ROUND) || (fsm == S_FINAL);

endmodule

// File: tb/tb_stv_aes_decipher.sv
// Directed bench: FIPS-197 vectors against AES-128 and AES-256 instances.
module tb_stv_aes_decipher;

  localparam logic [127:0] C1_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C3_CT = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  stv_aes_decipher_if b10 ();
  stv_aes_decipher_if b14 ();

  stv_aes_decipher #(.ROUNDS(10)) d10 (.clk(clk), .rst_n(rst_n), .bus(b10.slave));
  stv_aes_decipher #(.ROUNDS(14)) d14 (.clk(clk), .rst_n(rst_n), .bus(b14.slave));

  // Key-schedule storage models; ksel picks which AES-128 schedule is loaded.
  logic [127:0] rkc1 [16];
  logic [127:0] rkb  [16];
  logic [127:0] rk14 [16];
  bit           ksel;

  always_comb b10.rk_data = ksel ? rkb[b10.rk_idx] : rkc1[b10.rk_idx];
  always_comb b14.rk_data = rk14[b14.rk_idx];

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit           ks;
    logic [127:0] ct;
    logic [127:0] pt;
    int           stall;
  } vec_t;

  vec_t vt [4];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One block through the ROUNDS=10 instance; call at a negedge with the DUT idle.
  // Counting the accepting edge as edge 1, out_valid first shows after edge 11.
  task automatic run_block(input bit ks, input logic [127:0] ct, input logic [127:0] pt,
                           input int stall, input string nm);
    int n;
    bit rk_ok;
    bit hold_ok;
    ksel = ks;
    chk({nm, " idle rk_idx"}, 128'(b10.rk_idx), 128'd10);
    b10.in_valid  = 1'b1;
    b10.in_data   = ct;
    b10.out_ready = (stall == 0);
    @(negedge clk);
    b10.in_valid = 1'b0;
    b10.in_data  = '0;
    n = 1;
    rk_ok = 1'b1;
    while (!b10.out_valid && n < 40) begin
      if (b10.rk_idx != 4'(10 - n) || !b10.busy || b10.in_ready) rk_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    chk({nm, " latency"}, 128'(n), 128'd11);
    chk({nm, " rk_idx/busy seq"}, 128'(rk_ok), 128'd1);
    chk({nm, " out_data"}, b10.out_data, pt);
    hold_ok = 1'b1;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      if (!b10.out_valid || b10.out_data !== pt || b10.in_ready) hold_ok = 1'b0;
    end
    if (stall > 0) chk({nm, " held under backpressure"}, 128'(hold_ok), 128'd1);
    b10.out_ready = 1'b1;
    @(negedge clk);
    chk({nm, " back to idle"}, 128'({b10.in_ready, b10.out_valid, b10.busy}), 128'(3'b100));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int t1, t2, nout, n;
    bit acc, ok_a, ok_b, ok_c, stray, rk_ok;
    logic [127:0] outs [2];

    rkc1 = '{128'h000102030405060708090a0b0c0d0e0f, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
             128'hb692cf0b643dbdf1be9bc5006830b3fe, 128'hb6ff744ed2c2c9bf6c590cbf0469bf41,
             128'h47f7f7bc95353e03f96c32bcfd058dfd, 128'h3caaa3e8a99f9deb50f3af57adf622aa,
             128'h5e390f7df7a69296a7553dc10aa31f6b, 128'h14f9701ae35fe28c440adf4d4ea9c026,
             128'h47438735a41c65b9e016baf4aebf7ad2, 128'h549932d1f08557681093ed9cbe2c974e,
             128'h13111d7fe3944a17f307a78b4d2b30c5, '0, '0, '0, '0, '0};
    rkb  = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
             128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
             128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
             128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
             128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
             128'hd014f9a8c9ee2589e13f0cc8b6630ca6, '0, '0, '0, '0, '0};
    rk14 = '{128'h000102030405060708090a0b0c0d0e0f, 128'h101112131415161718191a1b1c1d1e1f,
             128'ha573c29fa176c498a97fce93a572c09c, 128'h1651a8cd0244beda1a5da4c10640bade,
             128'hae87dff00ff11b68a68ed5fb03fc1567, 128'h6de1f1486fa54f9275f8eb5373b8518d,
             128'hc656827fc9a799176f294cec6cd5598b, 128'h3de23a75524775e727bf9eb45407cf39,
             128'h0bdc905fc27b0948ad5245a4c1871c2f, 128'h45f5a66017b2d387300d4d33640a820a,
             128'h7ccff71cbeb4fe5413e6bbf0d261a7df, 128'hf01afafee7a82979d7a5644ab3afe640,
             128'h2541fe719bf500258813bbd55a721c0a, 128'h4e5a6699a9f24fe07e572baacdf8cdea,
             128'h24fc79ccbf0979e9371ac23c6d68de36, '0};

    vt[0] = '{1'b0, C1_CT, C1_PT, 0};
    vt[1] = '{1'b1, B_CT,  B_PT,  0};
    vt[2] = '{1'b0, C1_CT, C1_PT, 5};
    vt[3] = '{1'b1, B_CT,  B_PT,  2};

    ksel = 1'b0;
    rst_n = 1'b0;
    b10.in_valid = 1'b0; b10.in_data = '0; b10.out_ready = 1'b0;
    b14.in_valid = 1'b0; b14.in_data = '0; b14.out_ready = 1'b0;
    repeat (2) @(negedge clk);

    // Reset values.
    chk("reset in_ready",  128'(b10.in_ready),  128'd1);
    chk("reset out_valid", 128'(b10.out_valid), 128'd0);
    chk("reset busy",      128'(b10.busy),      128'd0);
    chk("reset out_data",  b10.out_data,        128'd0);
    chk("reset rk_idx",    128'(b10.rk_idx),    128'd10);
    chk("reset rk_idx r14", 128'(b14.rk_idx),   128'd14);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven vectors, with and without output backpressure.
    for (int i = 0; i < 4; i++)
      run_block(vt[i].ks, vt[i].ct, vt[i].pt, vt[i].stall, $sformatf("vec%0d", i));

    // Back-to-back with in_valid held high; the key store is reloaded once
    // the first block is done reading keys.
    ksel = 1'b0;
    b10.out_ready = 1'b1;
    b10.in_valid  = 1'b1;
    b10.in_data   = C1_CT;
    t1 = -1; t2 = -1; nout = 0;
    outs[0] = '0; outs[1] = '0;
    for (int t = 0; t < 40; t++) begin
      if (b10.out_valid) begin
        if (nout < 2) outs[nout] = b10.out_data;
        nout++;
        ksel = 1'b1;
      end
      acc = b10.in_valid && b10.in_ready;
      if (acc) begin
        if (t1 < 0) t1 = t;
        else t2 = t;
      end
      @(negedge clk);
      if (acc) begin
        if (t2 < 0) b10.in_data = B_CT;
        else b10.in_valid = 1'b0;
      end
    end
    chk("b2b accept spacing", 128'(t2 - t1), 128'd12);
    chk("b2b output count", 128'(nout), 128'd2);
    chk("b2b first out", outs[0], C1_PT);
    chk("b2b second out", outs[1], B_PT);
    ksel = 1'b0;

    // Idle stability.
    ok_a = 1'b1; ok_b = 1'b1; ok_c = 1'b1;
    repeat (50) begin
      @(negedge clk);
      if (b10.out_valid) ok_a = 1'b0;
      if (b10.busy) ok_b = 1'b0;
      if (b10.rk_idx != 4'd10) ok_c = 1'b0;
    end
    chk("idle out_valid low", 128'(ok_a), 128'd1);
    chk("idle busy low", 128'(ok_b), 128'd1);
    chk("idle rk_idx steady", 128'(ok_c), 128'd1);

    // ROUNDS=14 with the C.3 vector: keys 14 down to 0, latency 15.
    chk("r14 idle rk_idx", 128'(b14.rk_idx), 128'd14);
    b14.in_valid = 1'b1; b14.in_data = C3_CT; b14.out_ready = 1'b1;
    @(negedge clk);
    b14.in_valid = 1'b0;
    n = 1;
    rk_ok = 1'b1;
    while (!b14.out_valid && n < 40) begin
      if (b14.rk_idx != 4'(14 - n) || !b14.busy) rk_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    chk("r14 latency", 128'(n), 128'd15);
    chk("r14 rk_idx seq", 128'(rk_ok), 128'd1);
    chk("r14 out_data", b14.out_data, C1_PT);
    @(negedge clk);
    chk("r14 back to idle", 128'({b14.in_ready, b14.out_valid}), 128'(2'b10));

    // Reset during round 5 drops the block.
    ksel = 1'b0;
    b10.out_ready = 1'b1;
    b10.in_valid = 1'b1; b10.in_data = C1_CT;
    @(negedge clk);
    b10.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midreset flags", 128'({b10.out_valid, b10.in_ready, b10.busy}), 128'(3'b010));
    chk("midreset rk_idx", 128'(b10.rk_idx), 128'd10);
    rst_n = 1'b1;
    stray = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (b10.out_valid) stray = 1'b1;
    end
    chk("midreset no stray output", 128'(stray), 128'd0);
    run_block(1'b0, C1_CT, C1_PT, 0, "after reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
